// File: rtl/mfcc_melbank_reader.sv
// Streams a burst of melbank ROM coefficients out over a valid/ready port.
// Optional macro MELBANK_CHKSUM_EN adds a running checksum output.
module mfcc_melbank_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   burst_len,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic [DATA_WIDTH-1:0] coef_data,
   output logic                  coef_valid,
   input  logic                  coef_ready,
   output logic                  coef_last,
   output logic                  busy,
`ifdef MELBANK_CHKSUM_EN
   output logic [DATA_WIDTH-1:0] chksum,
`endif
   output logic                  done
);

   localparam int DEPTH = RD_LATENCY + 1;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH:0]   issue_left;
   logic [ADDR_WIDTH:0]   pop_left;
   logic                  done_q;

   logic [RD_LATENCY:1]   vld_pipe;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;

   logic                  push;
   logic                  pop;
   logic                  issue;
   logic [CW-1:0]         inflight;
   logic [CW:0]           occ;

   assign push = vld_pipe[RD_LATENCY];
   assign pop  = (count != '0) && coef_ready;

   // The word leaving this cycle frees its slot, which keeps the stream at one
   // word per clock while still guaranteeing every in-flight read has room.
   always_comb begin
      inflight = '0;
      for (int i = 1; i <= RD_LATENCY; i++)
         inflight = inflight + CW'(vld_pipe[i]);
      occ   = {1'b0, inflight} + {1'b0, count} - (CW+1)'(pop);
      issue = (state == FETCH) && (occ < (CW+1)'(DEPTH));
   end

   assign rom_addr   = addr;
   assign coef_data  = mem[rd_ptr];
   assign coef_valid = (count != '0);
   assign coef_last  = coef_valid && (pop_left == (ADDR_WIDTH+1)'(1));
   assign busy       = (state != IDLE);
   assign done       = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         issue_left <= '0;
         pop_left   <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (burst_len == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state      <= FETCH;
                     addr       <= base_addr;
                     issue_left <= burst_len;
                     pop_left   <= burst_len;
                  end
               end
            end
            FETCH: begin
               if (issue) begin
                  addr       <= addr + 1'b1;
                  issue_left <= issue_left - 1'b1;
                  if (issue_left == (ADDR_WIDTH+1)'(1))
                     state <= DRAIN;
               end
            end
            default: ;
         endcase
         // The last word can only leave after every address is out, i.e. in DRAIN.
         if (pop) begin
            pop_left <= pop_left - 1'b1;
            if (pop_left == (ADDR_WIDTH+1)'(1)) begin
               state  <= IDLE;
               done_q <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         vld_pipe[1] <= issue;
         for (int i = RD_LATENCY; i > 1; i--)
            vld_pipe[i] <= vld_pipe[i-1];
         if (push) begin
            mem[wr_ptr] <= rom_rd_data;
            wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef MELBANK_CHKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum_q <= '0;
      else if (state == IDLE && start)
         sum_q <= '0;
      else if (pop)
         sum_q <= sum_q + coef_data;
   end

   assign chksum = sum_q;
`endif

endmodule

// File: tb/tb_mfcc_melbank_reader.sv
// Bench for mfcc_melbank_reader: two instances (RD_LATENCY 1 and 2) against a
// queue-based model of the ROM burst stream.
module tb_mfcc_melbank_reader;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int NW = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          start [2];
   logic [AW-1:0] base_addr;
   logic [AW:0]   burst_len;
   logic          coef_ready;
   logic [AW-1:0] rom_addr   [2];
   logic [DW-1:0] rom_rd_data[2];
   logic [DW-1:0] coef_data  [2];
   logic          coef_valid [2];
   logic          coef_last  [2];
   logic          busy       [2];
   logic          done       [2];
`ifdef MELBANK_CHKSUM_EN
   logic [DW-1:0] chksum     [2];
   int            sum_at_done[2];
`endif

   always #5 clk = ~clk;

   mfcc_melbank_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr), .burst_len(burst_len),
      .rom_addr(rom_addr[0]), .rom_rd_data(rom_rd_data[0]), .coef_data(coef_data[0]),
      .coef_valid(coef_valid[0]), .coef_ready(coef_ready), .coef_last(coef_last[0]),
      .busy(busy[0]),
`ifdef MELBANK_CHKSUM_EN
      .chksum(chksum[0]),
`endif
      .done(done[0]));

   mfcc_melbank_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_l2 (
      .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr), .burst_len(burst_len),
      .rom_addr(rom_addr[1]), .rom_rd_data(rom_rd_data[1]), .coef_data(coef_data[1]),
      .coef_valid(coef_valid[1]), .coef_ready(coef_ready), .coef_last(coef_last[1]),
      .busy(busy[1]),
`ifdef MELBANK_CHKSUM_EN
      .chksum(chksum[1]),
`endif
      .done(done[1]));

   // ROM models: one and two registered read stages
   logic [DW-1:0] rom [NW];
   logic [DW-1:0] rd_stage;
   always @(posedge clk) rom_rd_data[0] <= rom[rom_addr[0]];
   always @(posedge clk) begin
      rd_stage       <= rom[rom_addr[1]];
      rom_rd_data[1] <= rd_stage;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Expected stream per instance
   logic [DW-1:0] expq [2][$];
   int   got [2], ndone [2], first_cyc [2], last_cyc [2], done_cyc [2];
   logic stall_prev [2];
   logic [DW-1:0] prev_data [2];
   logic prev_last [2];
   bit   chain_en = 0;
   bit   chained [2];
   int   chain_base, chain_len;
   int   rdy_pct = 100;

   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            if (stall_prev[k]) begin
               chk($sformatf("hold_valid%0d", k), coef_valid[k], 1);
               chk($sformatf("hold_data%0d", k), coef_data[k], prev_data[k]);
               chk($sformatf("hold_last%0d", k), coef_last[k], prev_last[k]);
            end
            stall_prev[k] = coef_valid[k] && !coef_ready;
            prev_data[k]  = coef_data[k];
            prev_last[k]  = coef_last[k];
            if (coef_valid[k] && coef_ready) begin
               if (expq[k].size() == 0)
                  chk($sformatf("extra_word%0d", k), 1, 0);
               else begin
                  chk($sformatf("data%0d", k), coef_data[k], expq[k][0]);
                  chk($sformatf("last%0d", k), coef_last[k], int'(expq[k].size() == 1));
                  void'(expq[k].pop_front());
               end
               if (got[k] == 0) first_cyc[k] = cyc;
               last_cyc[k] = cyc;
               got[k]++;
            end
            if (done[k]) begin
               ndone[k]++;
               done_cyc[k] = cyc;
               chk($sformatf("done_busy%0d", k), busy[k], 0);
`ifdef MELBANK_CHKSUM_EN
               sum_at_done[k] = chksum[k];
`endif
               // start on the very clock done is high must be honoured
               if (chain_en && !chained[k]) begin
                  chained[k] = 1;
                  start[k]   = 1'b1;
                  for (int i = 0; i < chain_len; i++)
                     expq[k].push_back(rom[(chain_base + i) % NW]);
               end
            end else if (chain_en && chained[k] && start[k]) begin
               start[k] = 1'b0;
            end
         end
      end else begin
         stall_prev[0] = 0;
         stall_prev[1] = 0;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_pct < 100) coef_ready = ($urandom_range(0, 99) < rdy_pct);
      end
   end

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_rom_addr%0d", tag, k), rom_addr[k], 0);
         chk($sformatf("%s_coef_data%0d", tag, k), coef_data[k], 0);
         chk($sformatf("%s_coef_valid%0d", tag, k), coef_valid[k], 0);
         chk($sformatf("%s_coef_last%0d", tag, k), coef_last[k], 0);
         chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
         chk($sformatf("%s_done%0d", tag, k), done[k], 0);
      end
   endtask

   task automatic prep(input int b, input int l);
      for (int k = 0; k < 2; k++) begin
         expq[k].delete();
         got[k] = 0; ndone[k] = 0; first_cyc[k] = -1; last_cyc[k] = -1; done_cyc[k] = -1;
         for (int i = 0; i < l; i++) expq[k].push_back(rom[(b + i) % NW]);
      end
   endtask

   // Returns the cycle number at which the DUTs sample start.
   task automatic pulse_start(input int b, input int l, output int s);
      @(posedge clk); #1;
      base_addr = AW'(b);
      burst_len = (AW+1)'(l);
      start[0] = 1'b1; start[1] = 1'b1;
      s = cyc + 1;
      @(posedge clk); #1;
      start[0] = 1'b0; start[1] = 1'b0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int t;
      t = 0;
      while (!(ndone[0] >= n && ndone[1] >= n) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      chk({tag, "_timeout"}, int'(t < 20000), 1);
   endtask

   task automatic run_burst(input int b, input int l, input int pct, input int exp_words,
                            input int exp_first, input string tag);
      int s;
      prep(b, l);
      rdy_pct = pct;
      if (pct >= 100) coef_ready = 1'b1;
      pulse_start(b, l, s);
      wait_done(1, tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_words%0d", tag, k), got[k], exp_words);
         chk($sformatf("%s_ndone%0d", tag, k), ndone[k], 1);
         chk($sformatf("%s_leftover%0d", tag, k), expq[k].size(), 0);
         if (exp_words == 0)
            chk($sformatf("%s_done_at%0d", tag, k), done_cyc[k] - s, 0);
         else begin
            chk($sformatf("%s_done_gap%0d", tag, k), done_cyc[k] - last_cyc[k], 1);
            if (exp_first >= 0) begin
               chk($sformatf("%s_first%0d", tag, k), first_cyc[k] - s, exp_first + k);
               chk($sformatf("%s_rate%0d", tag, k), last_cyc[k] - first_cyc[k], exp_words - 1);
            end
         end
      end
      rdy_pct = 100;
      coef_ready = 1'b1;
   endtask

   typedef struct {
      int base;
      int len;
      int pct;
      int exp_words;
      int exp_first;  // start-to-first-word clocks for RD_LATENCY 1, -1 if stalled
   } vec_t;

   vec_t vecs [7];

   initial begin
      int s, t;
      vecs[0] = '{base: 0,   len: 512, pct: 100, exp_words: 512, exp_first: 2};
      vecs[1] = '{base: 510, len: 4,   pct: 100, exp_words: 4,   exp_first: 2};
      vecs[2] = '{base: 77,  len: 0,   pct: 100, exp_words: 0,   exp_first: -1};
      vecs[3] = '{base: 5,   len: 1,   pct: 100, exp_words: 1,   exp_first: 2};
      vecs[4] = '{base: 37,  len: 100, pct: 50,  exp_words: 100, exp_first: -1};
      vecs[5] = '{base: 300, len: 512, pct: 70,  exp_words: 512, exp_first: -1};
      vecs[6] = '{base: 511, len: 2,   pct: 100, exp_words: 2,   exp_first: 2};

      for (int i = 0; i < NW; i++) rom[i] = DW'(i);
      rst = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
      base_addr = '0; burst_len = '0; coef_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst = 1'b0;

      for (int v = 0; v < 7; v++)
         run_burst(vecs[v].base, vecs[v].len, vecs[v].pct, vecs[v].exp_words,
                   vecs[v].exp_first, $sformatf("vec%0d", v));

`ifdef MELBANK_CHKSUM_EN
      run_burst(0, 16, 100, 16, 2, "chk16");
      chk("chksum0", sum_at_done[0], 120);
      chk("chksum1", sum_at_done[1], 120);
`endif

      // Reset in mid-burst after 10 accepted words
      prep(0, 64);
      coef_ready = 1'b1;
      pulse_start(0, 64, s);
      t = 0;
      while (got[0] < 10 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      chk("rst_reach10", int'(got[0] >= 10), 1);
      #1 rst = 1'b1;
      expq[0].delete(); expq[1].delete();
      @(posedge clk); #1;
      check_reset_vals("midrst");
      ndone[0] = 0; ndone[1] = 0;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      chk("rst_nodone0", ndone[0], 0);
      chk("rst_nodone1", ndone[1], 0);
      run_burst(120, 20, 100, 20, 2, "post_rst");

      // Random ROM contents and random bursts
      for (int i = 0; i < NW; i++) rom[i] = DW'($urandom);
      for (int r = 0; r < 6; r++) begin
         int b, l, p;
         b = $urandom_range(0, NW - 1);
         l = $urandom_range(1, NW);
         p = (r % 2 == 0) ? 100 : $urandom_range(30, 90);
         run_burst(b, l, p, l, (p >= 100) ? 2 : -1, $sformatf("rnd%0d", r));
      end

      // start during FETCH is ignored; start on the done clock is honoured
      prep(20, 40);
      chain_en = 1; chained[0] = 0; chained[1] = 0;
      chain_base = 200; chain_len = 8;
      coef_ready = 1'b1;
      pulse_start(20, 40, s);
      repeat (4) @(posedge clk);
      chk("fetch_busy0", busy[0], 1);
      pulse_start(100, 3, s);
      base_addr = AW'(chain_base);
      burst_len = (AW+1)'(chain_len);
      wait_done(2, "chain");
      chain_en = 0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("chain_words%0d", k), got[k], 48);
         chk($sformatf("chain_ndone%0d", k), ndone[k], 2);
         chk($sformatf("chain_leftover%0d", k), expq[k].size(), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
